c0_out_capture: RTL and testbench

Change-capture stage directly downstream of `top_c0`. It samples the 12-bit `o` bus every clock and logs each new value with a timestamp into a small FIFO. Software or a bench drains the FIFO through a valid/ready port. The result is a cycle-accurate trace of the combinational netlist's output without probing its internal instances.

---
 rtl/c0_cap_pkg.sv | 13 +
 rtl/cap_fifo.sv | 76 +++++++
 rtl/c0_out_capture.sv | 106 ++++++++++
 tb/tb_c0_out_capture.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/c0_cap_pkg.sv
// Shared constants and entry layout for the top_c0 output change-capture block.
package c0_cap_pkg;

  localparam int C0_OUT_W  = 12;
  localparam int CAP_DEPTH = 4;
  localparam int CAP_TS_W  = 8;

  typedef struct packed {
    logic [CAP_TS_W-1:0] ts;
    logic [C0_OUT_W-1:0] data;
  } cap_entry_t;

endpackage

// File: rtl/cap_fifo.sv
// Synchronous FIFO with a registered head entry; a full FIFO still accepts a
// push when the head is popped in the same cycle.
module cap_fifo #(
  parameter int DW    = 20,
  parameter int DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic [DW-1:0]           wdata_i,
  input  logic                    pop_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic [DW-1:0]           head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] head_q, head_d;
  logic          full_s, empty_s, push_ok_s, pop_ok_s;

  // Occupancy, pointer and head-of-queue next-state logic.
  always_comb begin
    full_s    = (count_q == FULL_CNT);
    empty_s   = (count_q == '0);
    pop_ok_s  = pop_i && !empty_s;
    push_ok_s = push_i && (!full_s || pop_i);
    count_d   = count_q + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
    wr_ptr_d  = wr_ptr_q + AW'(push_ok_s);
    rd_ptr_d  = rd_ptr_q + AW'(pop_ok_s);
    head_d    = head_q;
    // When nothing older survives this cycle the new head is the entry being written.
    if (count_d != '0) begin
      if (count_q == (AW+1)'(pop_ok_s)) begin
        head_d = wdata_i;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end else begin
      head_d = head_q;
    end
  end

  // Storage, pointers and registered head.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign full_o  = full_s;
  assign empty_o = empty_s;
  assign count_o = count_q;
  assign head_o  = head_q;

endmodule

// File: rtl/c0_out_capture.sv
// Samples top_c0.o every cycle and logs each new value with a timestamp into a
// small FIFO drained through a valid/ready port.
module c0_out_capture
  import c0_cap_pkg::*;
#(
  parameter int WIDTH = C0_OUT_W,
  parameter int DEPTH = CAP_DEPTH,
  parameter int TS_W  = CAP_TS_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [WIDTH-1:0]        smp_in,
  input  logic                    clr_ovf,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [TS_W-1:0]         out_ts,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  logic [TS_W-1:0]       ts_q;
  logic [WIDTH-1:0]      samp_q;
  logic [TS_W-1:0]       samp_ts_q;
  logic                  samp_v_q;
  logic [WIDTH-1:0]      prev_q, prev_d;
  logic                  armed_q, armed_d;
  logic                  ovf_q, ovf_d;
  logic                  push_s, pop_s, drop_s, full_s, empty_s;
  logic [TS_W+WIDTH-1:0] wr_entry_s, head_s;

  // Compare stage, history update and sticky overflow next-state.
  always_comb begin
    push_s     = samp_v_q && (armed_q || (samp_q != prev_q));
    pop_s      = out_ready && !empty_s;
    drop_s     = push_s && full_s && !pop_s;
    wr_entry_s = {samp_ts_q, samp_q};
    if (samp_v_q) begin
      prev_d = samp_q;
    end else begin
      prev_d = prev_q;
    end
    // Holding armed while disabled makes the first sample after re-enable always log.
    if (!en) begin
      armed_d = 1'b1;
    end else if (samp_v_q) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Timestamp counter, capture stage and compare-stage state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q      <= '0;
      samp_q    <= '0;
      samp_ts_q <= '0;
      samp_v_q  <= 1'b0;
      prev_q    <= '0;
      armed_q   <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (en) begin
        samp_q    <= smp_in;
        samp_ts_q <= ts_q;
        samp_v_q  <= 1'b1;
      end else begin
        samp_v_q  <= 1'b0;
      end
      prev_q  <= prev_d;
      armed_q <= armed_d;
      ovf_q   <= ovf_d;
    end
  end

  cap_fifo #(
    .DW    (TS_W + WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push_s),
    .wdata_i (wr_entry_s),
    .pop_i   (pop_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count),
    .head_o  (head_s)
  );

  assign out_valid = !empty_s;
  assign out_ts    = head_s[TS_W+WIDTH-1:WIDTH];
  assign out_data  = head_s[WIDTH-1:0];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_c0_out_capture.sv
// Randomised and directed bench for c0_out_capture against a queue-based model.
module tb_c0_out_capture;
  import c0_cap_pkg::*;

  localparam int DEPTH = CAP_DEPTH;

  logic        clk = 1'b0;
  logic        rst, en, clr_ovf, out_ready, out_valid, overflow;
  logic [11:0] smp_in, out_data;
  logic [7:0]  out_ts;
  logic [2:0]  count;
  logic [24:0] obs_s;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: logged entries, pending sample decision, timestamp.
  cap_entry_t mq[$];
  cap_entry_t got_q[$];
  cap_entry_t pend, m_head;
  logic       pend_v, fresh, m_ovf;
  logic [11:0] last;
  logic [7:0]  m_ts;

  c0_out_capture dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .smp_in    (smp_in),
    .clr_ovf   (clr_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ts    (out_ts),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  assign obs_s = {out_valid, count, overflow, out_data, out_ts};

  task automatic model_reset();
    mq.delete();
    pend_v = 1'b0; pend = '0; fresh = 1'b1; m_ovf = 1'b0;
    last = 12'h000; m_ts = 8'd0; m_head = '0;
  endtask

  // A value is logged if it is the first enabled sample or differs from the
  // previous enabled sample; it lands in the queue one edge after capture.
  task automatic model_edge(input logic e, input logic [11:0] s, input logic r, input logic c);
    logic drop;
    drop = 1'b0;
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (pend_v) begin
      if (mq.size() < DEPTH) mq.push_back(pend);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    pend_v = 1'b0;
    if (e) begin
      if (fresh || s != last) begin
        pend_v = 1'b1;
        pend.ts = m_ts;
        pend.data = s;
      end
      last = s;
      fresh = 1'b0;
    end else begin
      fresh = 1'b1;
    end
    m_ts = m_ts + 8'd1;
    if (mq.size() > 0) m_head = mq[0];
  endtask

  function automatic logic [24:0] model_exp();
    logic [2:0] c;
    c = 3'(mq.size());
    return {mq.size() > 0, c, m_ovf, m_head.data, m_head.ts};
  endfunction

  // Called at a falling edge: drive, advance the model, run one rising edge.
  task automatic step(input logic e, input logic [11:0] s, input logic r, input logic c);
    en = e; smp_in = s; out_ready = r; clr_ovf = c;
    if (r && out_valid) got_q.push_back(cap_entry_t'({out_ts, out_data}));
    model_edge(e, s, r, c);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; smp_in = 12'h000; out_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if (obs_s !== 25'd0) begin
      n_err++; $display("FAIL reset_state: got %h exp %h", obs_s, 25'd0);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_sample();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 12'h000, 1'b0, 1'b0);
      n_cmp++;
      if (obs_s !== model_exp()) begin
        n_err++; $display("FAIL first_sample cyc %0d: got %h exp %h", i, obs_s, model_exp());
      end
    end
    n_cmp++;
    if (count !== 3'd1 || out_ts !== 8'd0 || out_data !== 12'h000) begin
      n_err++; $display("FAIL first_entry: got cnt %0d ts %h d %h exp 1 00 000", count, out_ts, out_data);
    end
  endtask

  task automatic test_steps();
    logic [11:0] seq [7];
    seq = '{12'hA5A, 12'hA5B, 12'hA5B, 12'h3C0, 12'h3C0, 12'h3C0, 12'h3C0};
    step(1'b1, 12'h000, 1'b1, 1'b0);
    step(1'b1, 12'h000, 1'b1, 1'b0);
    got_q.delete();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, seq[i], 1'b1, 1'b0);
      n_cmp++;
      if (obs_s !== model_exp()) begin
        n_err++; $display("FAIL steps cyc %0d: got %h exp %h", i, obs_s, model_exp());
      end
    end
    n_cmp++;
    if (got_q.size() != 3) begin
      n_err++; $display("FAIL steps_count: got %0d exp 3", got_q.size());
    end else begin
      n_cmp++;
      if (got_q[0].data !== 12'hA5A || got_q[1].data !== 12'hA5B || got_q[2].data !== 12'h3C0 ||
          8'(got_q[1].ts - got_q[0].ts) !== 8'd1 || 8'(got_q[2].ts - got_q[1].ts) !== 8'd2) begin
        n_err++;
        $display("FAIL steps_order: got %h/%h %h/%h %h/%h exp A5A,A5B,3C0 ts +1 +2",
                 got_q[0].data, got_q[0].ts, got_q[1].data, got_q[1].ts, got_q[2].data, got_q[2].ts);
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 12'h100 + 12'(i < 6 ? i : 5), 1'b0, 1'b0);
      n_cmp++;
      if (obs_s !== model_exp()) begin
        n_err++; $display("FAIL overflow cyc %0d: got %h exp %h", i, obs_s, model_exp());
      end
    end
    n_cmp++;
    if (count !== 3'd4 || overflow !== 1'b1 || out_data !== 12'h100) begin
      n_err++; $display("FAIL overflow_full: got cnt %0d ovf %b d %h exp 4 1 100", count, overflow, out_data);
    end
    step(1'b1, 12'h105, 1'b0, 1'b1);
    n_cmp++;
    if (overflow !== 1'b0 || count !== 3'd4) begin
      n_err++; $display("FAIL clr_ovf: got ovf %b cnt %0d exp 0 4", overflow, count);
    end
  endtask

  task automatic test_full_pop();
    step(1'b1, 12'h7E7, 1'b0, 1'b0);
    step(1'b1, 12'h7E7, 1'b1, 1'b0);
    n_cmp++;
    if (count !== 3'd4 || overflow !== 1'b0 || obs_s !== model_exp()) begin
      n_err++; $display("FAIL full_pop: got %h exp %h", obs_s, model_exp());
    end
    got_q.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 12'h7E7, 1'b1, 1'b0);
    n_cmp++;
    if (got_q.size() != 4 || got_q[0].data !== 12'h101 || got_q[1].data !== 12'h102 ||
        got_q[2].data !== 12'h103 || got_q[3].data !== 12'h7E7) begin
      n_err++; $display("FAIL full_pop_order: got %0d entries exp 101,102,103,7E7", got_q.size());
    end
  endtask

  task automatic test_ts_wrap();
    for (int i = 0; i < 300 && m_ts != 8'd255; i++) step(1'b1, 12'h7E7, 1'b1, 1'b0);
    got_q.delete();
    step(1'b1, 12'h0F0, 1'b0, 1'b0);
    step(1'b1, 12'h0F0, 1'b0, 1'b0);
    step(1'b1, 12'h0F1, 1'b0, 1'b0);
    step(1'b1, 12'h0F1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 12'h0F1, 1'b1, 1'b0);
    n_cmp++;
    if (got_q.size() != 2 || got_q[0].ts !== 8'd255 || got_q[1].ts !== 8'd1) begin
      n_err++; $display("FAIL ts_wrap: got %0d entries ts %h %h exp ff 01", got_q.size(),
                        got_q.size() > 0 ? got_q[0].ts : 8'h00, got_q.size() > 1 ? got_q[1].ts : 8'h00);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 7) != 0, 12'h3A0 + 12'($urandom_range(0, 3)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      n_cmp++;
      if (obs_s !== model_exp()) begin
        n_err++; $display("FAIL random cyc %0d: got %h exp %h", i, obs_s, model_exp());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 12'h000, 1'b1, 1'b0);
    step(1'b1, 12'h011, 1'b0, 1'b0);
    step(1'b1, 12'h022, 1'b0, 1'b0);
    step(1'b1, 12'h033, 1'b0, 1'b0);
    step(1'b1, 12'h033, 1'b0, 1'b0);
    n_cmp++;
    if (count !== 3'd3 || obs_s !== model_exp()) begin
      n_err++; $display("FAIL pre_reset: got %h exp %h", obs_s, model_exp());
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got v %b cnt %0d ovf %b exp 0 0 0", out_valid, count, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 12'h000, 1'b0, 1'b0);
      n_cmp++;
      if (obs_s !== model_exp()) begin
        n_err++; $display("FAIL after_reset cyc %0d: got %h exp %h", i, obs_s, model_exp());
      end
    end
    n_cmp++;
    if (count !== 3'd1 || out_data !== 12'h000 || out_ts !== 8'd0) begin
      n_err++; $display("FAIL rearm: got cnt %0d d %h ts %h exp 1 000 00", count, out_data, out_ts);
    end
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_steps();
    test_overflow();
    test_full_pop();
    test_ts_wrap();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
